nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder built around one cla_4bit instance.
- Operand nibbles are fed through the cla_4bit one per clock, least-significant nibble first. The carry is registered between nibbles.
- Sits directly upstream of cla_4bit: drives its a, b and c_in, and consumes its sum and c_out.
- Trades latency for area on wide datapaths where a full-width CLA is too large.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4; N = WIDTH/4 nibbles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; a, b and c_in are sampled on the same edge.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry into bit 0.
- busy  output  1  high while the addition is in progress (RUN state).
- done  output  1  one-cycle pulse; sum and c_out are valid.
- sum  output  WIDTH  result; held until the next accepted start.
- c_out  output  1  carry out of bit WIDTH-1; held like sum.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, c_out=0. Internal operand registers, carry register and nibble index are also 0.
- States:
  - IDLE: waiting for start.
  - RUN: processing nibbles.
  - DONE: result presented.
- IDLE -> RUN on an edge with start=1. On that edge: latch a, b and c_in into internal registers; idx<=0; carry<=c_in; clear sum and c_out to 0.
- RUN, each edge:
  - cla_4bit is driven with a_reg[4*idx+:4], b_reg[4*idx+:4] and carry.
  - sum[4*idx+:4] <= cla sum; carry <= cla c_out; idx <= idx+1.
  - On the edge where idx==N-1: c_out <= cla c_out, state <= DONE.
- DONE: done=1 for exactly one cycle. If start=1 on that edge, the new operands are accepted (same actions as IDLE -> RUN), giving back-to-back operation. Otherwise -> IDLE.
- Latency: start sampled at edge E0. busy is high for cycles E0..E0+N-1; done is high in the cycle following edge E0+N. Throughput is one addition per N+1 cycles.
- busy = (state==RUN); done = (state==DONE). Both are registered state decodes, with no combinational path from inputs.
- start while in RUN is ignored; operands in flight are unaffected.
- Changes on a, b or c_in after acceptance have no effect; operands come from internal registers only.
- sum and c_out outputs change only during RUN, and on clear at acceptance.
  - Intermediate sum nibbles during RUN are not meaningful to consumers.
  - Consumers read the result on done or later.
- Reset mid-operation (any state): next cycle is IDLE with all outputs at reset values. No done pulse is produced for the aborted operation.
- Reset and start asserted together: reset wins and start is ignored.
- Arithmetic: {c_out,sum} = a + b + c_in, exactly modulo 2^(WIDTH+1). No truncation of the carry chain.
- idx is ceil(log2(N)) bits wide, minimum 1, and never exceeds N-1. For N=1, RUN lasts one edge.
- The cla_4bit p_block and g_block outputs are unused and left unconnected.

Optional Feature:
- Macro: NSA_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit) after c_out.
  - overflow reports two's-complement signed overflow: on the final RUN edge, overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (cla sum[3] != a_reg[WIDTH-1]).
  - Held like sum. Reset value 0; cleared to 0 on acceptance.
- Not defined: the port does not exist and no related logic is synthesized.

Test Plan:
- WIDTH=16: a=0x1234, b=0x4321, c_in=0, start pulse -> busy high 4 cycles, done pulse on 5th cycle, sum=0x5555, c_out=0.
- a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1 (carry ripples through all 4 nibbles). Also a=0x0000, b=0x0000, c_in=1 -> sum=0x0001, c_out=0.
- Back-to-back: start held high through done.
  - Second pair a=0x00FF, b=0x0F01 accepted on the DONE edge.
  - Done pulses exactly 5 cycles apart; second sum=0x1000, c_out=0.
- Start pulsed during RUN with different operands -> ignored; original result and timing unchanged. Operand inputs toggled during RUN -> result unchanged.
- rst asserted at 2nd RUN cycle -> next cycle busy=0, done=0, sum=0, c_out=0. No done pulse follows. A subsequent start completes normally.
- NSA_OVERFLOW_EN defined:
  - 0x7FFF+0x0001 -> sum=0x8000, overflow=1, c_out=0.
  - 0x8000+0x8000 -> sum=0x0000, overflow=1, c_out=1.
  - 0x1234+0x4321 -> overflow=0.
  - Random 1000-vector compare against a+b+c_in in both build configurations.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one cla_4bit reused per nibble, LSB nibble first, carry registered between nibbles.
// Define NSA_OVERFLOW_EN to add the signed-overflow output port.

module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out,
  output logic       p_block,
  output logic       g_block
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  always_comb begin
    p = a ^ b;
    g = a & b;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    p_block = &p;
    g_block = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    c_out = g_block | (p_block & c_in);
    sum = p ^ c;
  end
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef NSA_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);
  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               c_out_q, c_out_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               accept;
  logic               last;

  logic [3:0] cla_a, cla_b, cla_sum;
  logic       cla_c_out;

  assign cla_a = a_q[4*idx_q +: 4];
  assign cla_b = b_q[4*idx_q +: 4];
  assign last  = (idx_q == IDX_W'(N - 1));

  cla_4bit u_cla (
    .a       (cla_a),
    .b       (cla_b),
    .c_in    (carry_q),
    .sum     (cla_sum),
    .c_out   (cla_c_out),
    .p_block (),
    .g_block ()
  );

`ifdef NSA_OVERFLOW_EN
  logic overflow_q, overflow_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    idx_d   = idx_q;
    accept  = 1'b0;
`ifdef NSA_OVERFLOW_EN
    overflow_d = overflow_q;
`endif

    case (state_q)
      IDLE: accept = start;
      RUN: begin
        sum_d[4*idx_q +: 4] = cla_sum;
        carry_d = cla_c_out;
        if (last) begin
          c_out_d = cla_c_out;
          idx_d   = '0;
          state_d = DONE;
`ifdef NSA_OVERFLOW_EN
          overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (cla_sum[3] != a_q[WIDTH-1]);
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        accept  = start;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Acceptance from IDLE or DONE is identical, which is what makes back-to-back work
    if (accept) begin
      a_d     = a;
      b_d     = b;
      carry_d = c_in;
      idx_d   = '0;
      sum_d   = '0;
      c_out_d = 1'b0;
      state_d = RUN;
`ifdef NSA_OVERFLOW_EN
      overflow_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      idx_q   <= '0;
`ifdef NSA_OVERFLOW_EN
      overflow_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      idx_q   <= idx_d;
`ifdef NSA_OVERFLOW_EN
      overflow_q <= overflow_d;
`endif
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;
`ifdef NSA_OVERFLOW_EN
  assign overflow = overflow_q;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random self-checking bench for nibble_serial_adder (WIDTH=16).
// Build with NSA_OVERFLOW_EN defined to also check the overflow port.

module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        c_in;
  logic        busy, done;
  logic [15:0] sum;
  logic        c_out;
`ifdef NSA_OVERFLOW_EN
  logic        overflow;
`endif

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
`ifdef NSA_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulses start for one edge; returns at the first negedge after acceptance
  task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    @(negedge clk);
    a = va; b = vb; c_in = vc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedge samples (starting at 'first') until done is seen, bounded
  task automatic waitDone(input int first, output int cycles, output int busyCnt, output bit seen);
    cycles = first; busyCnt = 0; seen = 1'b0;
    while (cycles <= 20) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busyCnt++;
      @(negedge clk);
      cycles++;
    end
    checkOutput("done_timeout", 32'(seen), 32'd1);
  endtask

  int   cyc, bcnt;
  bit   seen;
  logic [16:0] expFull;
  logic [15:0] ra, rb;
  logic        rc;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy",  32'(busy),  32'd0);
    checkOutput("reset_done",  32'(done),  32'd0);
    checkOutput("reset_sum",   32'(sum),   32'd0);
    checkOutput("reset_c_out", 32'(c_out), 32'd0);
    rst = 1'b0;

    // Basic add with latency check
    applyStimulus(16'h1234, 16'h4321, 1'b0);
    waitDone(1, cyc, bcnt, seen);
    checkOutput("basic_busy_cycles", 32'(bcnt), 32'd4);
    checkOutput("basic_done_cycle",  32'(cyc),  32'd5);
    checkOutput("basic_sum",   32'(sum),   32'h5555);
    checkOutput("basic_c_out", 32'(c_out), 32'd0);
`ifdef NSA_OVERFLOW_EN
    checkOutput("basic_overflow", 32'(overflow), 32'd0);
`endif
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("sum_held", 32'(sum), 32'h5555);

    // Full carry ripple
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    waitDone(1, cyc, bcnt, seen);
    checkOutput("ripple_sum",   32'(sum),   32'h0000);
    checkOutput("ripple_c_out", 32'(c_out), 32'd1);

    // Carry-in only
    applyStimulus(16'h0000, 16'h0000, 1'b1);
    waitDone(1, cyc, bcnt, seen);
    checkOutput("cin_sum",   32'(sum),   32'h0001);
    checkOutput("cin_c_out", 32'(c_out), 32'd0);

    // Back-to-back with start held high through done
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 16'h00FF; b = 16'h0F01;
    waitDone(1, cyc, bcnt, seen);
    checkOutput("b2b_first_cycle", 32'(cyc), 32'd5);
    checkOutput("b2b_first_sum",   32'(sum), 32'h5555);
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_accepted_busy", 32'(busy), 32'd1);
    waitDone(1, cyc, bcnt, seen);
    checkOutput("b2b_spacing",      32'(cyc),   32'd5);
    checkOutput("b2b_second_sum",   32'(sum),   32'h1000);
    checkOutput("b2b_second_c_out", 32'(c_out), 32'd0);

    // Start and operand changes during RUN are ignored
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    a = 16'h1111; b = 16'h2222; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'hAAAA; b = 16'h5555;
    @(negedge clk);
    waitDone(3, cyc, bcnt, seen);
    checkOutput("ignore_done_cycle", 32'(cyc),   32'd5);
    checkOutput("ignore_sum",        32'(sum),   32'h0000);
    checkOutput("ignore_c_out",      32'(c_out), 32'd1);

    // Reset at the second RUN cycle aborts with no done pulse
    applyStimulus(16'h1234, 16'h4321, 1'b0);
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checkOutput("abort_busy",  32'(busy),  32'd0);
    checkOutput("abort_done",  32'(done),  32'd0);
    checkOutput("abort_sum",   32'(sum),   32'd0);
    checkOutput("abort_c_out", 32'(c_out), 32'd0);
    bcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) bcnt++;
    end
    checkOutput("abort_no_activity", 32'(bcnt), 32'd0);
    applyStimulus(16'h0F0F, 16'h0101, 1'b1);
    waitDone(1, cyc, bcnt, seen);
    checkOutput("after_abort_sum", 32'(sum), 32'h1011);

`ifdef NSA_OVERFLOW_EN
    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    waitDone(1, cyc, bcnt, seen);
    checkOutput("ovf_pos_sum",   32'(sum),      32'h8000);
    checkOutput("ovf_pos_flag",  32'(overflow), 32'd1);
    checkOutput("ovf_pos_c_out", 32'(c_out),    32'd0);
    applyStimulus(16'h8000, 16'h8000, 1'b0);
    waitDone(1, cyc, bcnt, seen);
    checkOutput("ovf_neg_sum",   32'(sum),      32'h0000);
    checkOutput("ovf_neg_flag",  32'(overflow), 32'd1);
    checkOutput("ovf_neg_c_out", 32'(c_out),    32'd1);
    applyStimulus(16'h1234, 16'h4321, 1'b0);
    waitDone(1, cyc, bcnt, seen);
    checkOutput("ovf_none_flag", 32'(overflow), 32'd0);
`endif

    // Random vectors against a+b+c_in
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      expFull = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
      applyStimulus(ra, rb, rc);
      waitDone(1, cyc, bcnt, seen);
      checkOutput("rand_sum",   32'(sum),   32'(expFull[15:0]));
      checkOutput("rand_c_out", 32'(c_out), 32'(expFull[16]));
`ifdef NSA_OVERFLOW_EN
      checkOutput("rand_overflow", 32'(overflow),
                  32'((ra[15] == rb[15]) && (expFull[15] != ra[15])));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
